// File: rtl/complete.sv
// Complete/retire stage: 16-entry ROB, result-bus broadcast
// and in-order retirement of up to two instructions per cycle.
module complete (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_flag_ci,
  output logic        en_flag_co,
  input  logic [31:0] result_c1,
  input  logic [31:0] result_c2,
  input  logic [31:0] result_c3,
  input  logic [5:0]  result_dest_c1,
  input  logic [5:0]  result_dest_c2,
  input  logic [5:0]  result_dest_c3,
  input  logic        result_valid_c1,
  input  logic        result_valid_c2,
  input  logic        result_valid_c3,
  input  logic [3:0]  result_ROB_c1,
  input  logic [3:0]  result_ROB_c2,
  input  logic [3:0]  result_ROB_c3,
  input  logic [1:0]  result_FU_c1,
  input  logic [1:0]  result_FU_c2,
  input  logic [1:0]  result_FU_c3,
  input  logic        update_rob,
  input  logic [6:0]  rob_opcode_1,
  input  logic [6:0]  rob_opcode_2,
  input  logic [5:0]  rob_p_reg_1,
  input  logic [5:0]  rob_p_reg_2,
  input  logic [5:0]  o_rob_p_reg_1,
  input  logic [5:0]  o_rob_p_reg_2,
  input  logic [4:0]  rob_rd_1,
  input  logic [4:0]  rob_rd_2,
  output logic [3:0]  rob_tail,
  output logic        rob_full,
  output logic        forward_flag_1,
  output logic        forward_flag_2,
  output logic        forward_flag_3,
  output logic [5:0]  dest_R_1,
  output logic [5:0]  dest_R_2,
  output logic [5:0]  dest_R_3,
  output logic [31:0] forwarded_data_1,
  output logic [31:0] forwarded_data_2,
  output logic [31:0] forwarded_data_3,
  output logic        retire_flag_1,
  output logic        retire_flag_2,
  output logic [5:0]  fp_ind_1,
  output logic [5:0]  fp_ind_2,
  output logic [4:0]  retire_index_1,
  output logic [4:0]  retire_index_2,
  output logic [31:0] retire_result_1,
  output logic [31:0] retire_result_2,
  input  logic [31:0] total_instr_count,
  output logic        pr_flag
);

  typedef struct packed {
    logic        valid;
    logic        is_store;
    logic [5:0]  preg;
    logic [5:0]  opreg;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        done;
  } rob_t;

  localparam logic [6:0] OP_STORE = 7'b0100011;

  rob_t        rob [16];
  logic [3:0]  head;
  logic [3:0]  tail;
  logic [4:0]  count;
  logic [31:0] retired;

  logic [3:0]  head_p1;
  logic [3:0]  tail_p1;
  logic        ret1;
  logic        ret2;
  logic        wr1;
  logic        wr2;
  logic        alloc1;
  logic        alloc2;
  logic [1:0]  nret;
  logic [1:0]  nalloc;

  logic        cv [3];
  logic [3:0]  ci [3];
  logic [31:0] cd [3];

  logic unused;
  assign unused = ^{result_FU_c1, result_FU_c2, result_FU_c3};

  assign rob_tail = tail;
  assign rob_full = count > 5'd14;
  assign head_p1  = head + 4'd1;
  assign tail_p1  = tail + 4'd1;

  assign ret1 = rob[head].valid && rob[head].done;
  assign ret2 = ret1 && rob[head_p1].valid && rob[head_p1].done;
  assign wr1  = ret1 && !rob[head].is_store;
  assign wr2  = ret2 && !rob[head_p1].is_store;

  assign alloc1 = update_rob && !rob_full && (rob_opcode_1 != 7'd0);
  assign alloc2 = alloc1 && (rob_opcode_2 != 7'd0);
  assign nret   = {1'b0, ret1} + {1'b0, ret2};
  assign nalloc = {1'b0, alloc1} + {1'b0, alloc2};

  always_comb begin
    cv[0] = result_valid_c1;
    cv[1] = result_valid_c2;
    cv[2] = result_valid_c3;
    ci[0] = result_ROB_c1;
    ci[1] = result_ROB_c2;
    ci[2] = result_ROB_c3;
    cd[0] = result_c1;
    cd[1] = result_c2;
    cd[2] = result_c3;
  end

  // Later buses overwrite earlier ones; retire clears last so it wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rob[i] <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      retired <= '0;
    end else begin
      if (alloc1)
        rob[tail] <= '{1'b1, rob_opcode_1 == OP_STORE,
                       rob_p_reg_1, o_rob_p_reg_1,
                       rob_rd_1, 32'd0, 1'b0};
      if (alloc2)
        rob[tail_p1] <= '{1'b1, rob_opcode_2 == OP_STORE,
                          rob_p_reg_2, o_rob_p_reg_2,
                          rob_rd_2, 32'd0, 1'b0};
      for (int n = 0; n < 3; n++) begin
        if (cv[n] && rob[ci[n]].valid) begin
          rob[ci[n]].result <= cd[n];
          rob[ci[n]].done   <= 1'b1;
        end
      end
      if (ret1) begin
        rob[head].valid <= 1'b0;
        rob[head].done  <= 1'b0;
      end
      if (ret2) begin
        rob[head_p1].valid <= 1'b0;
        rob[head_p1].done  <= 1'b0;
      end
      head    <= head + {2'b00, nret};
      tail    <= tail + {2'b00, nalloc};
      count   <= count + {3'b000, nalloc} - {3'b000, nret};
      retired <= retired + {30'd0, nret};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_flag_co       <= 1'b0;
      forward_flag_1   <= 1'b0;
      forward_flag_2   <= 1'b0;
      forward_flag_3   <= 1'b0;
      dest_R_1         <= '0;
      dest_R_2         <= '0;
      dest_R_3         <= '0;
      forwarded_data_1 <= '0;
      forwarded_data_2 <= '0;
      forwarded_data_3 <= '0;
      retire_flag_1    <= 1'b0;
      retire_flag_2    <= 1'b0;
      fp_ind_1         <= '0;
      fp_ind_2         <= '0;
      retire_index_1   <= '0;
      retire_index_2   <= '0;
      retire_result_1  <= '0;
      retire_result_2  <= '0;
      pr_flag          <= 1'b0;
    end else begin
      en_flag_co       <= en_flag_ci;
      forward_flag_1   <= result_valid_c1;
      forward_flag_2   <= result_valid_c2;
      forward_flag_3   <= result_valid_c3;
      dest_R_1         <= result_dest_c1;
      dest_R_2         <= result_dest_c2;
      dest_R_3         <= result_dest_c3;
      forwarded_data_1 <= result_c1;
      forwarded_data_2 <= result_c2;
      forwarded_data_3 <= result_c3;
      retire_flag_1    <= wr1;
      retire_flag_2    <= wr2;
      fp_ind_1         <= wr1 ? rob[head].opreg : '0;
      fp_ind_2         <= wr2 ? rob[head_p1].opreg : '0;
      retire_index_1   <= wr1 ? rob[head].rd : '0;
      retire_index_2   <= wr2 ? rob[head_p1].rd : '0;
      retire_result_1  <= wr1 ? rob[head].result : '0;
      retire_result_2  <= wr2 ? rob[head_p1].result : '0;
      if (total_instr_count != 32'd0 &&
          retired == total_instr_count)
        pr_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_complete.sv
// Bench for complete: forward/retire scoreboards, a forwarding
// vector table and hand-written ROB sequences.
`timescale 1ns/1ps
module tb_complete;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en_ci;
  logic        en_co;
  logic [3:1]  rv;
  logic [31:0] rdata [1:3];
  logic [5:0]  rdest [1:3];
  logic [3:0]  rrob  [1:3];
  logic [1:0]  fu;
  logic        upd;
  logic [6:0]  op1, op2;
  logic [5:0]  pr1, pr2, opr1, opr2;
  logic [4:0]  rd1, rd2;
  logic [3:0]  tail;
  logic        full;
  logic [3:1]  ff;
  logic [5:0]  fdest [1:3];
  logic [31:0] fdata [1:3];
  logic        rf1, rf2;
  logic [5:0]  fp1, fp2;
  logic [4:0]  ri1, ri2;
  logic [31:0] rr1, rr2;
  logic [31:0] total;
  logic        pr;

  complete dut (
    .clk(clk), .rst_n(rst_n),
    .en_flag_ci(en_ci), .en_flag_co(en_co),
    .result_c1(rdata[1]), .result_c2(rdata[2]),
    .result_c3(rdata[3]),
    .result_dest_c1(rdest[1]), .result_dest_c2(rdest[2]),
    .result_dest_c3(rdest[3]),
    .result_valid_c1(rv[1]), .result_valid_c2(rv[2]),
    .result_valid_c3(rv[3]),
    .result_ROB_c1(rrob[1]), .result_ROB_c2(rrob[2]),
    .result_ROB_c3(rrob[3]),
    .result_FU_c1(fu), .result_FU_c2(fu), .result_FU_c3(fu),
    .update_rob(upd),
    .rob_opcode_1(op1), .rob_opcode_2(op2),
    .rob_p_reg_1(pr1), .rob_p_reg_2(pr2),
    .o_rob_p_reg_1(opr1), .o_rob_p_reg_2(opr2),
    .rob_rd_1(rd1), .rob_rd_2(rd2),
    .rob_tail(tail), .rob_full(full),
    .forward_flag_1(ff[1]), .forward_flag_2(ff[2]),
    .forward_flag_3(ff[3]),
    .dest_R_1(fdest[1]), .dest_R_2(fdest[2]), .dest_R_3(fdest[3]),
    .forwarded_data_1(fdata[1]), .forwarded_data_2(fdata[2]),
    .forwarded_data_3(fdata[3]),
    .retire_flag_1(rf1), .retire_flag_2(rf2),
    .fp_ind_1(fp1), .fp_ind_2(fp2),
    .retire_index_1(ri1), .retire_index_2(ri2),
    .retire_result_1(rr1), .retire_result_2(rr2),
    .total_instr_count(total), .pr_flag(pr)
  );

  localparam logic [6:0] ALU = 7'b0110011;
  localparam logic [6:0] STO = 7'b0100011;

  typedef struct packed {
    logic             en;
    logic [3:1]       f;
    logic [3:1][5:0]  d;
    logic [3:1][31:0] v;
  } fwd_t;

  typedef struct packed {
    logic [5:0]  fp;
    logic [4:0]  rd;
    logic [31:0] res;
  } ret_t;

  typedef struct {
    int          bus;
    logic [5:0]  dest;
    logic [31:0] data;
    logic        ef;
    logic [5:0]  ed;
    logic [31:0] edata;
  } fv_t;

  fwd_t fq[$];
  ret_t rq[$];
  fv_t  fv [4];
  int   checks = 0;
  int   errors = 0;

  function automatic ret_t mk(int fp, int rd, int res);
    ret_t r;
    r.fp  = 6'(fp);
    r.rd  = 5'(rd);
    r.res = 32'(res);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_ret(input int p, input logic f,
                         input logic [5:0] fp, input logic [4:0] ri,
                         input logic [31:0] rr);
    ret_t e;
    if (f) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ret%0d_unexpected: got rd=%0d expected none",
                 p, ri);
      end else begin
        e = rq.pop_front();
        chk($sformatf("ret%0d_fp", p), 32'(fp), 32'(e.fp));
        chk($sformatf("ret%0d_rd", p), 32'(ri), 32'(e.rd));
        chk($sformatf("ret%0d_res", p), rr, e.res);
      end
    end else begin
      chk($sformatf("ret%0d_idle_data", p),
          32'((|fp) | (|ri) | (|rr)), 32'd0);
    end
  endtask

  task automatic cyc();
    fwd_t e;
    e.en = en_ci;
    e.f  = rv;
    for (int n = 1; n <= 3; n++) begin
      e.d[n] = rdest[n];
      e.v[n] = rdata[n];
    end
    fq.push_back(e);
    @(posedge clk);
    #1;
    e = fq.pop_front();
    chk("en_flag_co", 32'(en_co), 32'(e.en));
    for (int n = 1; n <= 3; n++) begin
      chk($sformatf("fwd%0d_flag", n), 32'(ff[n]), 32'(e.f[n]));
      chk($sformatf("fwd%0d_dest", n), 32'(fdest[n]), 32'(e.d[n]));
      chk($sformatf("fwd%0d_data", n), fdata[n], e.v[n]);
    end
    chk_ret(1, rf1, fp1, ri1, rr1);
    chk_ret(2, rf2, fp2, ri2, rr2);
  endtask

  task automatic zero_in();
    rv  = '0;
    upd = 1'b0;
    op1 = '0; op2 = '0;
    pr1 = '0; pr2 = '0; opr1 = '0; opr2 = '0;
    rd1 = '0; rd2 = '0;
    fu  = '0;
    for (int n = 1; n <= 3; n++) begin
      rdata[n] = '0;
      rdest[n] = '0;
      rrob[n]  = '0;
    end
  endtask

  task automatic chk_zero(input string nm);
    logic [31:0] acc;
    acc = 32'(en_co) | 32'(ff) | 32'(rf1) | 32'(rf2) | 32'(pr);
    for (int n = 1; n <= 3; n++)
      acc = acc | 32'(fdest[n]) | fdata[n];
    acc = acc | 32'(fp1) | 32'(fp2) | 32'(ri1) | 32'(ri2);
    acc = acc | rr1 | rr2;
    chk({nm, "_outputs"}, acc, 32'd0);
    chk({nm, "_tail"}, 32'(tail), 32'd0);
    chk({nm, "_full"}, 32'(full), 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    zero_in();
    rst_n = 1'b1;
  endtask

  task automatic alloc(input logic [6:0] o1, input logic [6:0] o2,
                       input int j);
    upd  = 1'b1;
    op1  = o1;
    op2  = o2;
    pr1  = 6'(32 + j);
    pr2  = 6'(33 + j);
    opr1 = 6'(j + 10);
    opr2 = 6'(j + 11);
    rd1  = 5'(j + 1);
    rd2  = 5'(j + 2);
    cyc();
    upd  = 1'b0;
  endtask

  task automatic no_ret(input string nm);
    chk(nm, 32'(rf1 | rf2), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fv[0] = '{2, 6'd40, 32'hDEADBEEF, 1'b1, 6'd40, 32'hDEADBEEF};
    fv[1] = '{1, 6'd1,  32'h12345678, 1'b1, 6'd1,  32'h12345678};
    fv[2] = '{3, 6'd63, 32'hFFFFFFFF, 1'b1, 6'd63, 32'hFFFFFFFF};
    fv[3] = '{2, 6'd0,  32'h00000000, 1'b1, 6'd0,  32'h00000000};

    zero_in();
    en_ci = 1'b0;
    total = '0;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      rv    = 3'($urandom);
      upd   = 1'($urandom);
      op1   = 7'($urandom);
      op2   = 7'($urandom);
      en_ci = 1'($urandom);
      total = $urandom;
      for (int n = 1; n <= 3; n++) begin
        rdata[n] = $urandom;
        rdest[n] = 6'($urandom);
        rrob[n]  = 4'($urandom);
      end
    end
    @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    zero_in();
    total = '0;
    rst_n = 1'b1;
    en_ci = 1'b1;
    cyc();
    chk("post_reset_tail", 32'(tail), 32'd0);

    foreach (fv[i]) begin
      rv[fv[i].bus]    = 1'b1;
      rdest[fv[i].bus] = fv[i].dest;
      rdata[fv[i].bus] = fv[i].data;
      cyc();
      chk($sformatf("vec%0d_flag", i), 32'(ff[fv[i].bus]),
          32'(fv[i].ef));
      chk($sformatf("vec%0d_dest", i), 32'(fdest[fv[i].bus]),
          32'(fv[i].ed));
      chk($sformatf("vec%0d_data", i), fdata[fv[i].bus],
          fv[i].edata);
      zero_in();
      en_ci = 1'($urandom);
      cyc();
      chk($sformatf("vec%0d_drop", i), 32'(ff[fv[i].bus]), 32'd0);
      no_ret($sformatf("vec%0d_no_retire", i));
    end
    en_ci = 1'b1;

    chk("tail_init", 32'(tail), 32'd0);
    upd = 1'b1; op1 = ALU; op2 = ALU;
    pr1 = 6'd33; pr2 = 6'd34; opr1 = 6'd5; opr2 = 6'd6;
    rd1 = 5'd5; rd2 = 5'd6;
    cyc();
    upd = 1'b0;
    chk("tail_pair", 32'(tail), 32'd2);
    rq.push_back(mk(5, 5, 3));
    rq.push_back(mk(6, 6, 7));
    rv[1] = 1'b1; rrob[1] = 4'd1; rdata[1] = 32'd7; rdest[1] = 6'd34;
    cyc();
    zero_in();
    no_ret("ooo_a");
    cyc();
    no_ret("ooo_b");
    rv[3] = 1'b1; rrob[3] = 4'd0; rdata[3] = 32'd3; rdest[3] = 6'd33;
    cyc();
    zero_in();
    no_ret("head_complete_edge");
    cyc();
    chk("dual_retire", 32'({rf1, rf2}), 32'd3);
    cyc();
    no_ret("retire_pulse");

    alloc(ALU, ALU, 20);
    chk("tail_before_reset", 32'(tail), 32'd4);
    rv[1] = 1'b1; rrob[1] = 4'd2; rdata[1] = 32'd11;
    rv[2] = 1'b1; rrob[2] = 4'd3; rdata[2] = 32'd12;
    cyc();
    apply_reset();
    cyc();
    no_ret("reset_no_retire_a");
    cyc();
    no_ret("reset_no_retire_b");

    total = 32'd1;
    alloc(STO, 7'd0, 0);
    chk("store_tail", 32'(tail), 32'd1);
    rv[2] = 1'b1; rrob[2] = 4'd0; rdata[2] = 32'd99;
    cyc();
    zero_in();
    cyc();
    chk("store_flag", 32'(rf1), 32'd0);
    chk("pr_before", 32'(pr), 32'd0);
    cyc();
    chk("pr_set", 32'(pr), 32'd1);
    total = 32'd5;
    cyc();
    chk("pr_sticky", 32'(pr), 32'd1);
    total = 32'd0;
    apply_reset();

    for (int i = 0; i < 9; i++) begin
      alloc(ALU, ALU, 2 * i);
      if (i < 8) begin
        rq.push_back(mk(2 * i + 10, 2 * i + 1, 100 + 2 * i));
        rq.push_back(mk(2 * i + 11, 2 * i + 2, 101 + 2 * i));
      end
      if (i == 6) begin
        chk("fill14_full", 32'(full), 32'd0);
        chk("fill14_tail", 32'(tail), 32'd14);
      end
      if (i == 7) begin
        chk("fill16_full", 32'(full), 32'd1);
        chk("fill16_wrap", 32'(tail), 32'd0);
      end
    end
    chk("drop_tail", 32'(tail), 32'd0);
    chk("drop_full", 32'(full), 32'd1);

    rv[1] = 1'b1; rrob[1] = 4'd0; rdata[1] = 32'd100;
    rv[2] = 1'b1; rrob[2] = 4'd1; rdata[2] = 32'd101;
    cyc();
    zero_in();
    cyc();
    chk("full_dual_retire", 32'({rf1, rf2}), 32'd3);
    chk("full_cleared", 32'(full), 32'd0);
    alloc(ALU, ALU, 16);
    rq.push_back(mk(26, 17, 116));
    rq.push_back(mk(27, 18, 117));
    chk("wrap_tail", 32'(tail), 32'd2);
    chk("wrap_full", 32'(full), 32'd1);

    rv[1] = 1'b1; rrob[1] = 4'd2; rdata[1] = 32'hBAD;
    rv[2] = 1'b1; rrob[2] = 4'd3; rdata[2] = 32'd103;
    rv[3] = 1'b1; rrob[3] = 4'd2; rdata[3] = 32'd102;
    cyc();
    zero_in();
    for (int j = 4; j <= 17; j += 3) begin
      for (int k = 0; k < 3; k++) begin
        if (j + k <= 17) begin
          rv[k + 1]    = 1'b1;
          rrob[k + 1]  = 4'((j + k) % 16);
          rdata[k + 1] = 32'(100 + j + k);
        end
      end
      cyc();
      zero_in();
    end
    for (int k = 0; k < 30 && rq.size() > 0; k++) cyc();
    chk("drain_empty", 32'(rq.size()), 32'd0);
    chk("drain_full", 32'(full), 32'd0);

    rv[3] = 1'b1; rrob[3] = 4'd5; rdest[3] = 6'd7;
    rdata[3] = 32'hABCD;
    cyc();
    zero_in();
    chk("stray_fwd", 32'(ff[3]), 32'd1);
    no_ret("stray_a");
    cyc();
    no_ret("stray_b");
    chk("stray_tail", 32'(tail), 32'd2);
    chk("stray_full", 32'(full), 32'd0);
    chk("final_queue", 32'(rq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
